intt_dispatch: RTL and testbench
================================

INTT_DISPATCH -- requirements
Module: intt_dispatch

Interface
REQ-001 Parameter NUM_INTT, default 2, number of iNTT units scheduled (1..2^`INTT_ID_WIDTH).
REQ-002 Parameter CNT_WIDTH, default 16, width of issue_count.
REQ-003 Port clk input 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst input 1: asynchronous, active-high reset.
REQ-005 Port in_valid input 1: the top controller presents an instruction.
REQ-006 Port in_ready output 1: the instruction is accepted when in_valid && in_ready.
REQ-007 Port in_opcode input `OPCODE_WIDTH; in_gate input 3; in_init_value input `LWE_BIT_WIDTH; in_subs_factor input 4.
REQ-008 Port rob_full input 1: reorder-buffer full flag.
REQ-009 Port rob_wr_en output 1: one-cycle reorder-buffer write strobe.
REQ-010 Port rob_opcode, rob_gate, rob_init_value and rob_subs_factor are outputs with the widths of the matching in_* ports; rob_iNTT_id output `INTT_ID_WIDTH.
REQ-011 Port intt_start output NUM_INTT: one-hot start pulse, one bit per iNTT unit.
REQ-012 Port intt_done input NUM_INTT: per-unit completion pulse.
REQ-013 Port busy output NUM_INTT: per-unit occupancy.
REQ-014 Port idle output 1: all units are free and no write is pending.
REQ-015 Port issue_count output CNT_WIDTH: total accepted instructions.
REQ-016 Port err_spurious_done output 1: sticky error flag.

Function
REQ-017 in_ready SHALL be combinational: !rob_full && !rob_wr_en && (busy != all-ones).
- The !rob_wr_en term covers the one-cycle-stale rob_full, so throughput is at most one instruction per two cycles.
REQ-018 On accept in cycle t, the block SHALL select a free unit sel using busy as sampled in cycle t.
REQ-019 At t+1 the block SHALL assert, for exactly one cycle:
- rob_wr_en=1 and intt_start[sel]=1;
- rob_iNTT_id=sel;
- rob_* fields equal to the in_* values captured at t.
REQ-020 busy[sel] SHALL be 1 from t+1.
REQ-021 rob_* data outputs SHALL hold their last value while rob_wr_en=0.
REQ-022 intt_done[k] in cycle t with busy[k]=1 SHALL clear busy[k] at t+1, and unit k SHALL be selectable from t+1.
REQ-023 intt_done[k] with busy[k]=0 SHALL leave busy unchanged and SHALL set err_spurious_done at t+1; the flag stays set until reset.
REQ-024 A done on one unit and an accept selecting a different unit in the same cycle SHALL both take effect.
- An accept can never select the unit being done, because busy is sampled before the clear.
REQ-025 issue_count SHALL increment by 1 per accept and wrap modulo 2^CNT_WIDTH.
REQ-026 idle SHALL equal (busy==0) && !rob_wr_en.
REQ-027 The block SHALL NOT interpret in_opcode or in_gate; both pass through unmodified.

Reset
REQ-028 While rst=1, and asynchronously on its assertion:
- busy=0, intt_start=0, rob_wr_en=0;
- all rob_* data outputs=0;
- issue_count=0, err_spurious_done=0;
- round-robin pointer=0.
REQ-029 While rst=1, in_ready SHALL be 0.
REQ-030 Reset asserted while a write is pending SHALL cancel that write; no rob_wr_en or intt_start pulse is issued after reset.
REQ-031 An instruction accepted in the cycle rst asserts SHALL be discarded.

Configuration
REQ-032 Macro INTT_DISPATCH_RR_EN defined: sel is the first free unit strictly after the last granted unit, wrapping, with the pointer starting at 0. The pointer SHALL update on each accept.
REQ-033 Macro INTT_DISPATCH_RR_EN undefined: sel is the lowest-index free unit (fixed priority), and no pointer register exists.

Verification
REQ-034 Reset, then in_valid=1 with opcode X, gate=`AND, init_value=5:
- next cycle rob_wr_en=1, intt_start=2'b01, rob_iNTT_id=0, rob_init_value=5;
- busy=2'b01, issue_count=1.
REQ-035 Two back-to-back valid instructions with no done (RR build): accepts land at cycles t and t+2; starts go to units 0 then 1; busy=2'b11 and in_ready=0 until a done arrives.
REQ-036 With busy=2'b11, intt_done=2'b10 at cycle t:
- busy=2'b01 at t+1;
- a pending instruction is accepted at t+1 and started on unit 1 at t+2.
REQ-037 rob_full=1 with a free unit and in_valid=1: in_ready=0 and no rob_wr_en pulse; when rob_full drops, the accept happens the same cycle.
REQ-038 intt_done=2'b01 with busy=2'b00: err_spurious_done=1 next cycle and stays 1; busy remains 2'b00.
REQ-039 rst pulsed the cycle after an accept: no rob_wr_en or intt_start pulse; all outputs return to their reset values.

Source files
------------

// File: rtl/intt_dispatch.sv
// intt_dispatch: accepts instructions, picks a free iNTT unit, logs the grant to the reorder buffer and starts it.
// Optional macro INTT_DISPATCH_RR_EN selects round-robin unit selection; default is lowest-index fixed priority.

`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef LWE_BIT_WIDTH
`define LWE_BIT_WIDTH 10
`endif
`ifndef INTT_ID_WIDTH
`define INTT_ID_WIDTH 2
`endif
`ifndef AND
`define AND 3'd1
`endif

module intt_dispatch #(
   parameter int NUM_INTT  = 2,
   parameter int CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [`OPCODE_WIDTH-1:0]  in_opcode,
   input  logic [2:0]                in_gate,
   input  logic [`LWE_BIT_WIDTH-1:0] in_init_value,
   input  logic [3:0]                in_subs_factor,
   input  logic                      rob_full,
   output logic                      rob_wr_en,
   output logic [`OPCODE_WIDTH-1:0]  rob_opcode,
   output logic [2:0]                rob_gate,
   output logic [`LWE_BIT_WIDTH-1:0] rob_init_value,
   output logic [3:0]                rob_subs_factor,
   output logic [`INTT_ID_WIDTH-1:0] rob_iNTT_id,
   output logic [NUM_INTT-1:0]       intt_start,
   input  logic [NUM_INTT-1:0]       intt_done,
   output logic [NUM_INTT-1:0]       busy,
   output logic                      idle,
   output logic [CNT_WIDTH-1:0]      issue_count,
   output logic                      err_spurious_done
);

   localparam int IDW = `INTT_ID_WIDTH;

   logic                      rob_wr_en_q, rob_wr_en_d;
   logic [NUM_INTT-1:0]       intt_start_q, intt_start_d;
   logic [NUM_INTT-1:0]       busy_q, busy_d;
   logic [`OPCODE_WIDTH-1:0]  rob_opcode_q, rob_opcode_d;
   logic [2:0]                rob_gate_q, rob_gate_d;
   logic [`LWE_BIT_WIDTH-1:0] rob_init_value_q, rob_init_value_d;
   logic [3:0]                rob_subs_factor_q, rob_subs_factor_d;
   logic [IDW-1:0]            rob_id_q, rob_id_d;
   logic [CNT_WIDTH-1:0]      issue_count_q, issue_count_d;
   logic                      err_q, err_d;

   logic                      accept;
   logic [IDW-1:0]            sel;
   logic                      sel_found;
   logic [NUM_INTT-1:0]       sel_onehot;

   // The pending-write term stands in for the reorder buffer's full flag, which lags one cycle.
   assign in_ready = !rst && !rob_full && !rob_wr_en_q && (busy_q != {NUM_INTT{1'b1}});
   assign accept   = in_valid && in_ready;

`ifdef INTT_DISPATCH_RR_EN
   logic [IDW-1:0] ptr_q, ptr_d;

   // ptr_q holds the first candidate to try, i.e. the unit just after the last grant.
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      for (int i = 0; i < NUM_INTT; i++) begin
         for (int k = 0; k < NUM_INTT; k++) begin
            if (!sel_found && !busy_q[k] && (k == (int'(ptr_q) + i) % NUM_INTT)) begin
               sel       = IDW'(k);
               sel_found = 1'b1;
            end
         end
      end
      ptr_d = accept ? IDW'((int'(sel) + 1) % NUM_INTT) : ptr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`else
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      for (int k = 0; k < NUM_INTT; k++) begin
         if (!sel_found && !busy_q[k]) begin
            sel       = IDW'(k);
            sel_found = 1'b1;
         end
      end
   end
`endif

   for (genvar gi = 0; gi < NUM_INTT; gi++) begin : g_onehot
      assign sel_onehot[gi] = (sel == IDW'(gi));
   end

   always_comb begin
      rob_wr_en_d       = accept;
      intt_start_d      = accept ? sel_onehot : '0;
      rob_opcode_d      = accept ? in_opcode      : rob_opcode_q;
      rob_gate_d        = accept ? in_gate        : rob_gate_q;
      rob_init_value_d  = accept ? in_init_value  : rob_init_value_q;
      rob_subs_factor_d = accept ? in_subs_factor : rob_subs_factor_q;
      rob_id_d          = accept ? sel            : rob_id_q;
      // A selected unit was free at sampling, so it can never collide with its own done.
      busy_d            = (busy_q & ~intt_done) | (accept ? sel_onehot : '0);
      err_d             = err_q | (|(intt_done & ~busy_q));
      issue_count_d     = issue_count_q + CNT_WIDTH'(accept);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rob_wr_en_q       <= 1'b0;
         intt_start_q      <= '0;
         busy_q            <= '0;
         rob_opcode_q      <= '0;
         rob_gate_q        <= '0;
         rob_init_value_q  <= '0;
         rob_subs_factor_q <= '0;
         rob_id_q          <= '0;
         issue_count_q     <= '0;
         err_q             <= 1'b0;
      end else begin
         rob_wr_en_q       <= rob_wr_en_d;
         intt_start_q      <= intt_start_d;
         busy_q            <= busy_d;
         rob_opcode_q      <= rob_opcode_d;
         rob_gate_q        <= rob_gate_d;
         rob_init_value_q  <= rob_init_value_d;
         rob_subs_factor_q <= rob_subs_factor_d;
         rob_id_q          <= rob_id_d;
         issue_count_q     <= issue_count_d;
         err_q             <= err_d;
      end
   end

   assign rob_wr_en         = rob_wr_en_q;
   assign intt_start        = intt_start_q;
   assign busy              = busy_q;
   assign rob_opcode        = rob_opcode_q;
   assign rob_gate          = rob_gate_q;
   assign rob_init_value    = rob_init_value_q;
   assign rob_subs_factor   = rob_subs_factor_q;
   assign rob_iNTT_id       = rob_id_q;
   assign issue_count       = issue_count_q;
   assign err_spurious_done = err_q;
   assign idle              = (busy_q == '0) && !rob_wr_en_q;

endmodule

// File: tb/tb_intt_dispatch.sv
// Directed testbench for intt_dispatch: reset, dispatch, back-to-back, done reuse, rob_full, spurious done, reset cancel, count wrap.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 6
`endif
`ifndef LWE_BIT_WIDTH
`define LWE_BIT_WIDTH 10
`endif
`ifndef INTT_ID_WIDTH
`define INTT_ID_WIDTH 2
`endif
`ifndef AND
`define AND 3'd1
`endif

module tb_intt_dispatch;

   logic                      clk;
   logic                      rst;
   logic                      in_valid;
   logic                      in_ready;
   logic [`OPCODE_WIDTH-1:0]  in_opcode;
   logic [2:0]                in_gate;
   logic [`LWE_BIT_WIDTH-1:0] in_init_value;
   logic [3:0]                in_subs_factor;
   logic                      rob_full;
   logic                      rob_wr_en;
   logic [`OPCODE_WIDTH-1:0]  rob_opcode;
   logic [2:0]                rob_gate;
   logic [`LWE_BIT_WIDTH-1:0] rob_init_value;
   logic [3:0]                rob_subs_factor;
   logic [`INTT_ID_WIDTH-1:0] rob_iNTT_id;
   logic [1:0]                intt_start;
   logic [1:0]                intt_done;
   logic [1:0]                busy;
   logic                      idle;
   logic [3:0]                issue_count;
   logic                      err_spurious_done;

   int passed = 0;
   int total  = 0;

   intt_dispatch #(.NUM_INTT(2), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_gate(in_gate),
      .in_init_value(in_init_value), .in_subs_factor(in_subs_factor),
      .rob_full(rob_full), .rob_wr_en(rob_wr_en),
      .rob_opcode(rob_opcode), .rob_gate(rob_gate),
      .rob_init_value(rob_init_value), .rob_subs_factor(rob_subs_factor),
      .rob_iNTT_id(rob_iNTT_id), .intt_start(intt_start),
      .intt_done(intt_done), .busy(busy), .idle(idle),
      .issue_count(issue_count), .err_spurious_done(err_spurious_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; intt_done = 2'b00; rob_full = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; rob_full = 1'b0; intt_done = 2'b00;
      in_opcode = 6'h11; in_gate = 3'd2; in_init_value = 10'd3; in_subs_factor = 4'd1;
      tick(); tick();
      $display("test_reset: rst held high with in_valid=1");
      total++; if (in_ready !== 1'b0) $display("FAIL reset.in_ready got=%0b exp=0", in_ready); else passed++;
      total++; if (rob_wr_en !== 1'b0) $display("FAIL reset.rob_wr_en got=%0b exp=0", rob_wr_en); else passed++;
      total++; if (intt_start !== 2'b00) $display("FAIL reset.intt_start got=%b exp=00", intt_start); else passed++;
      total++; if (busy !== 2'b00) $display("FAIL reset.busy got=%b exp=00", busy); else passed++;
      total++; if (issue_count !== 4'd0) $display("FAIL reset.issue_count got=%0d exp=0", issue_count); else passed++;
      total++; if (err_spurious_done !== 1'b0) $display("FAIL reset.err got=%0b exp=0", err_spurious_done); else passed++;
      total++; if (rob_init_value !== 10'd0) $display("FAIL reset.rob_init_value got=%0d exp=0", rob_init_value); else passed++;
      total++; if (idle !== 1'b1) $display("FAIL reset.idle got=%0b exp=1", idle); else passed++;
      in_valid = 1'b0;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_single_dispatch();
      do_reset();
      in_valid = 1'b1; in_opcode = 6'h2A; in_gate = `AND; in_init_value = 10'd5; in_subs_factor = 4'd3;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL single.in_ready_pre got=%0b exp=1", in_ready); else passed++;
      tick();
      in_valid = 1'b0;
      $display("test_single_dispatch: accepted opcode=2A gate=AND init=5");
      total++; if (rob_wr_en !== 1'b1) $display("FAIL single.rob_wr_en got=%0b exp=1", rob_wr_en); else passed++;
      total++; if (intt_start !== 2'b01) $display("FAIL single.intt_start got=%b exp=01", intt_start); else passed++;
      total++; if (rob_iNTT_id !== 2'd0) $display("FAIL single.rob_iNTT_id got=%0d exp=0", rob_iNTT_id); else passed++;
      total++; if (rob_init_value !== 10'd5) $display("FAIL single.rob_init_value got=%0d exp=5", rob_init_value); else passed++;
      total++; if (rob_opcode !== 6'h2A) $display("FAIL single.rob_opcode got=%h exp=2a", rob_opcode); else passed++;
      total++; if (rob_gate !== `AND) $display("FAIL single.rob_gate got=%0d exp=%0d", rob_gate, `AND); else passed++;
      total++; if (rob_subs_factor !== 4'd3) $display("FAIL single.rob_subs_factor got=%0d exp=3", rob_subs_factor); else passed++;
      total++; if (busy !== 2'b01) $display("FAIL single.busy got=%b exp=01", busy); else passed++;
      total++; if (issue_count !== 4'd1) $display("FAIL single.issue_count got=%0d exp=1", issue_count); else passed++;
      total++; if (idle !== 1'b0) $display("FAIL single.idle got=%0b exp=0", idle); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL single.in_ready_pend got=%0b exp=0", in_ready); else passed++;
      tick();
      total++; if (rob_wr_en !== 1'b0) $display("FAIL single.rob_wr_en_drop got=%0b exp=0", rob_wr_en); else passed++;
      total++; if (intt_start !== 2'b00) $display("FAIL single.intt_start_drop got=%b exp=00", intt_start); else passed++;
      total++; if (rob_init_value !== 10'd5) $display("FAIL single.rob_hold got=%0d exp=5", rob_init_value); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL single.in_ready_post got=%0b exp=1", in_ready); else passed++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      in_valid = 1'b1; in_opcode = 6'h01; in_gate = 3'd4; in_init_value = 10'd7; in_subs_factor = 4'd0;
      tick();
      $display("test_back_to_back: first accept init=7");
      total++; if (intt_start !== 2'b01) $display("FAIL b2b.start0 got=%b exp=01", intt_start); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL b2b.ready_gap got=%0b exp=0", in_ready); else passed++;
      in_init_value = 10'd8;
      tick();
      total++; if (rob_wr_en !== 1'b0) $display("FAIL b2b.gap_wr got=%0b exp=0", rob_wr_en); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL b2b.ready_second got=%0b exp=1", in_ready); else passed++;
      tick();
      $display("test_back_to_back: second accept init=8");
      total++; if (intt_start !== 2'b10) $display("FAIL b2b.start1 got=%b exp=10", intt_start); else passed++;
      total++; if (rob_iNTT_id !== 2'd1) $display("FAIL b2b.id1 got=%0d exp=1", rob_iNTT_id); else passed++;
      total++; if (rob_init_value !== 10'd8) $display("FAIL b2b.init1 got=%0d exp=8", rob_init_value); else passed++;
      total++; if (busy !== 2'b11) $display("FAIL b2b.busy got=%b exp=11", busy); else passed++;
      tick(); tick();
      total++; if (in_ready !== 1'b0) $display("FAIL b2b.ready_full got=%0b exp=0", in_ready); else passed++;
      total++; if (rob_wr_en !== 1'b0) $display("FAIL b2b.no_wr got=%0b exp=0", rob_wr_en); else passed++;
      total++; if (issue_count !== 4'd2) $display("FAIL b2b.issue_count got=%0d exp=2", issue_count); else passed++;
   endtask

   // Continues from the all-busy state left by test_back_to_back with in_valid still high.
   task automatic test_done_reuse();
      in_init_value = 10'd9;
      intt_done = 2'b10;
      tick();
      intt_done = 2'b00;
      #1;
      $display("test_done_reuse: done on unit 1");
      total++; if (busy !== 2'b01) $display("FAIL done.busy_clear got=%b exp=01", busy); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL done.ready got=%0b exp=1", in_ready); else passed++;
      total++; if (err_spurious_done !== 1'b0) $display("FAIL done.err got=%0b exp=0", err_spurious_done); else passed++;
      tick();
      in_valid = 1'b0;
      $display("test_done_reuse: pending accept init=9");
      total++; if (intt_start !== 2'b10) $display("FAIL done.start got=%b exp=10", intt_start); else passed++;
      total++; if (rob_iNTT_id !== 2'd1) $display("FAIL done.id got=%0d exp=1", rob_iNTT_id); else passed++;
      total++; if (rob_init_value !== 10'd9) $display("FAIL done.init got=%0d exp=9", rob_init_value); else passed++;
      total++; if (issue_count !== 4'd3) $display("FAIL done.issue_count got=%0d exp=3", issue_count); else passed++;
      intt_done = 2'b01;
      tick();
      intt_done = 2'b00;
      total++; if (busy !== 2'b10) $display("FAIL done.busy_u0 got=%b exp=10", busy); else passed++;
      in_valid = 1'b1; in_init_value = 10'd10;
      intt_done = 2'b10;
      tick();
      in_valid = 1'b0; intt_done = 2'b00;
      $display("test_done_reuse: done on unit 1 with accept to unit 0, init=10");
      total++; if (busy !== 2'b01) $display("FAIL done.concurrent_busy got=%b exp=01", busy); else passed++;
      total++; if (intt_start !== 2'b01) $display("FAIL done.concurrent_start got=%b exp=01", intt_start); else passed++;
      total++; if (issue_count !== 4'd4) $display("FAIL done.concurrent_count got=%0d exp=4", issue_count); else passed++;
      intt_done = 2'b01;
      tick();
      intt_done = 2'b00;
      total++; if (idle !== 1'b1) $display("FAIL done.idle got=%0b exp=1", idle); else passed++;
   endtask

   task automatic test_rob_full();
      do_reset();
      rob_full = 1'b1; in_valid = 1'b1; in_init_value = 10'd21;
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL robfull.ready got=%0b exp=0", in_ready); else passed++;
      tick(); tick();
      $display("test_rob_full: held off two cycles");
      total++; if (rob_wr_en !== 1'b0) $display("FAIL robfull.no_wr got=%0b exp=0", rob_wr_en); else passed++;
      total++; if (issue_count !== 4'd0) $display("FAIL robfull.count got=%0d exp=0", issue_count); else passed++;
      rob_full = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL robfull.ready_drop got=%0b exp=1", in_ready); else passed++;
      tick();
      in_valid = 1'b0;
      $display("test_rob_full: accept after rob_full drop init=21");
      total++; if (rob_wr_en !== 1'b1) $display("FAIL robfull.wr got=%0b exp=1", rob_wr_en); else passed++;
      total++; if (rob_init_value !== 10'd21) $display("FAIL robfull.init got=%0d exp=21", rob_init_value); else passed++;
   endtask

   task automatic test_spurious_done();
      do_reset();
      intt_done = 2'b01;
      tick();
      intt_done = 2'b00;
      $display("test_spurious_done: done on idle unit 0");
      total++; if (err_spurious_done !== 1'b1) $display("FAIL spur.err got=%0b exp=1", err_spurious_done); else passed++;
      total++; if (busy !== 2'b00) $display("FAIL spur.busy got=%b exp=00", busy); else passed++;
      tick(); tick();
      total++; if (err_spurious_done !== 1'b1) $display("FAIL spur.sticky got=%0b exp=1", err_spurious_done); else passed++;
   endtask

   task automatic test_priority();
      do_reset();
      in_valid = 1'b1; in_init_value = 10'd30;
      tick();
      intt_done = 2'b01;
      in_init_value = 10'd31;
      tick();
      intt_done = 2'b00;
      tick();
      in_valid = 1'b0;
      $display("test_priority: unit 0 freed, next accept init=31");
`ifdef INTT_DISPATCH_RR_EN
      total++; if (intt_start !== 2'b10) $display("FAIL prio.start got=%b exp=10", intt_start); else passed++;
`else
      total++; if (intt_start !== 2'b01) $display("FAIL prio.start got=%b exp=01", intt_start); else passed++;
`endif
      total++; if (rob_init_value !== 10'd31) $display("FAIL prio.init got=%0d exp=31", rob_init_value); else passed++;
   endtask

   task automatic test_reset_cancel();
      do_reset();
      in_valid = 1'b1; in_init_value = 10'd11;
      #2;
      rst = 1'b1;
      #1;
      $display("test_reset_cancel: rst asserted in accept cycle");
      total++; if (in_ready !== 1'b0) $display("FAIL rstc.ready got=%0b exp=0", in_ready); else passed++;
      in_valid = 1'b0;
      tick();
      total++; if (rob_wr_en !== 1'b0) $display("FAIL rstc.a_wr got=%0b exp=0", rob_wr_en); else passed++;
      total++; if (issue_count !== 4'd0) $display("FAIL rstc.a_count got=%0d exp=0", issue_count); else passed++;
      rst = 1'b0;
      tick();
      total++; if (intt_start !== 2'b00) $display("FAIL rstc.a_start got=%b exp=00", intt_start); else passed++;
      in_valid = 1'b1; in_init_value = 10'd12;
      tick();
      in_valid = 1'b0;
      total++; if (rob_wr_en !== 1'b1) $display("FAIL rstc.b_accept got=%0b exp=1", rob_wr_en); else passed++;
      #2;
      rst = 1'b1;
      #1;
      $display("test_reset_cancel: rst asserted with write pending");
      total++; if (rob_wr_en !== 1'b0) $display("FAIL rstc.b_wr got=%0b exp=0", rob_wr_en); else passed++;
      total++; if (intt_start !== 2'b00) $display("FAIL rstc.b_start got=%b exp=00", intt_start); else passed++;
      total++; if (busy !== 2'b00) $display("FAIL rstc.b_busy got=%b exp=00", busy); else passed++;
      total++; if (issue_count !== 4'd0) $display("FAIL rstc.b_count got=%0d exp=0", issue_count); else passed++;
      total++; if (rob_init_value !== 10'd0) $display("FAIL rstc.b_init got=%0d exp=0", rob_init_value); else passed++;
      tick();
      rst = 1'b0;
      tick();
      total++; if (rob_wr_en !== 1'b0) $display("FAIL rstc.after_wr got=%0b exp=0", rob_wr_en); else passed++;
      total++; if (idle !== 1'b1) $display("FAIL rstc.after_idle got=%0b exp=1", idle); else passed++;
   endtask

   task automatic test_count_wrap();
      do_reset();
      for (int n = 1; n <= 16; n++) begin
         in_valid = 1'b1; in_init_value = 10'(n);
         tick();
         in_valid = 1'b0;
         $display("test_count_wrap: accept %0d init=%0d count=%0d", n, n, issue_count);
         total++; if (rob_init_value !== 10'(n)) $display("FAIL wrap.init got=%0d exp=%0d", rob_init_value, n); else passed++;
         if (n == 15) begin
            total++; if (issue_count !== 4'd15) $display("FAIL wrap.count15 got=%0d exp=15", issue_count); else passed++;
         end
         if (n == 16) begin
            total++; if (issue_count !== 4'd0) $display("FAIL wrap.count16 got=%0d exp=0", issue_count); else passed++;
         end
         intt_done = intt_start;
         tick();
         intt_done = 2'b00;
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; rob_full = 1'b0; intt_done = 2'b00;
      in_opcode = '0; in_gate = '0; in_init_value = '0; in_subs_factor = '0;
      test_reset();
      test_single_dispatch();
      test_back_to_back();
      test_done_reuse();
      test_rob_full();
      test_spurious_done();
      test_priority();
      test_reset_cancel();
      test_count_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
